// File: rtl/io_capture_pkg.sv
// Shared constants, helpers and types for the IO-tile capture FIFO.
// Imported by the memory, interface and top-level files.
package io_capture_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_OVF_WIDTH  = 16;

  // Pointer width for a power-of-two depth; a single-entry store still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one extra bit so that a completely full store is representable.
  function automatic int level_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  typedef logic [level_width(DEFAULT_DEPTH)-1:0] level_t;

endpackage

// File: rtl/io_capture_fifo_if.sv
// Host-side stream carrying captured words out of the FIFO.
// valid/ready: a word transfers on a clock edge where host_valid and host_ready are both 1;
// while host_valid is 1 and host_ready is 0, host_data holds steady and host_valid stays high.
interface io_capture_fifo_if #(
  parameter int DATA_WIDTH = io_capture_pkg::DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] host_data;
  logic                  host_valid;
  logic                  host_ready;

  modport master (
    output host_data,
    output host_valid,
    input  host_ready
  );

  modport slave (
    input  host_data,
    input  host_valid,
    output host_ready
  );

endinterface

// File: rtl/io_capture_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, combinational read.
// Contents are deliberately left unreset; validity is tracked by the owner's level counter.
module io_capture_mem
  import io_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int PTR_W      = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/io_capture_fifo.sv
// Captures fabric IO-tile words on cap_en into a first-word-fall-through FIFO for the host;
// words offered while full (and not popped) are dropped and counted in a saturating counter.
module io_capture_fifo
  import io_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int OVF_WIDTH  = DEFAULT_OVF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cap_en,
  input  logic [DATA_WIDTH-1:0]  cap_data,
  io_capture_fifo_if.master      host,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic [OVF_WIDTH-1:0]   ovf_cnt,
  input  logic                   ovf_clr
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  localparam logic [LVL_W-1:0]     LEVEL_FULL = LVL_W'(DEPTH);
  localparam logic [OVF_WIDTH-1:0] OVF_MAX    = {OVF_WIDTH{1'b1}};

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level_q;
  logic [OVF_WIDTH-1:0] ovf_q;

  logic is_full;
  logic is_valid;
  logic pop;
  logic push;
  logic drop;

  // Status flags come only from registered state, so host_ready never reaches an output.
  assign is_full  = (level_q == LEVEL_FULL);
  assign is_valid = (level_q != '0);

  // A full FIFO still takes a word when the host frees a slot in the same cycle.
  assign pop  = is_valid & host.host_ready;
  assign push = cap_en & (~is_full | pop);
  assign drop = cap_en & is_full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // A drop coinciding with a clear leaves a count of one so the event is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= '0;
    end else if (ovf_clr) begin
      ovf_q <= drop ? OVF_WIDTH'(1) : '0;
    end else if (drop && (ovf_q != OVF_MAX)) begin
      ovf_q <= ovf_q + 1'b1;
    end
  end

  io_capture_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data (cap_data),
    .rd_ptr  (rd_ptr),
    .rd_data (host.host_data)
  );

  assign host.host_valid = is_valid;
  assign level           = level_q;
  assign full            = is_full;
  assign ovf_cnt         = ovf_q;

endmodule

// File: tb/tb_io_capture_fifo.sv
// Randomised and directed checks of io_capture_fifo against a queue-based reference model.
module tb_io_capture_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int OVF_W = 16;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic          clk;
  logic          rst;
  logic          cap_en;
  logic [W-1:0]  cap_data;
  logic [3:0]    level;
  logic          full;
  logic [OVF_W-1:0] ovf_cnt;
  logic          ovf_clr;

  io_capture_fifo_if #(.DATA_WIDTH(W)) host_if ();

  io_capture_fifo #(
    .DATA_WIDTH (W),
    .DEPTH      (DEPTH),
    .OVF_WIDTH  (OVF_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
    .cap_data (cap_data),
    .host     (host_if.master),
    .level    (level),
    .full     (full),
    .ovf_cnt  (ovf_cnt),
    .ovf_clr  (ovf_clr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued words in arrival order, plus the drop counter.
  logic [W-1:0] exp_q[$];
  int           exp_ovf;
  int           n_checks;
  int           n_fail;

  // Driver: apply one cycle of inputs at the falling edge, advance the model, wait for the next falling edge.
  task automatic step(input logic en, input logic [W-1:0] d, input logic rdy, input logic clr);
    bit m_pop, m_full, m_push, m_drop;
    cap_en             = en;
    cap_data           = d;
    host_if.host_ready = rdy;
    ovf_clr            = clr;
    m_full = (exp_q.size() == DEPTH);
    m_pop  = (exp_q.size() != 0) && rdy;
    m_push = en && (!m_full || m_pop);
    m_drop = en && m_full && !m_pop;
    if (m_pop)  void'(exp_q.pop_front());
    if (m_push) exp_q.push_back(d);
    if (clr)                             exp_ovf = m_drop ? 1 : 0;
    else if (m_drop && exp_ovf < OVF_MAX) exp_ovf = exp_ovf + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; cap_en = 1'b0; cap_data = '0; ovf_clr = 1'b0; host_if.host_ready = 1'b0;
    exp_q.delete(); exp_ovf = 0;
    #12;
    n_checks++; if (host_if.host_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", host_if.host_valid); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_ovf: got %h want 0", ovf_cnt); end
    @(negedge clk); rst = 1'b1;
    // host_ready with an empty FIFO must change nothing.
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (level !== 4'd0 || host_if.host_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got level %0d valid %b want 0 0", level, host_if.host_valid); end
  endtask

  task automatic test_single();
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    n_checks++; if (host_if.host_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", host_if.host_valid); end
    n_checks++; if (host_if.host_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", host_if.host_data); end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", level); end
    // Stalled host: head must hold.
    step(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (host_if.host_data !== 32'hDEADBEEF || host_if.host_valid !== 1'b1) begin n_fail++; $display("FAIL single_hold: got %h/%b want deadbeef/1", host_if.host_data, host_if.host_valid); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (host_if.host_valid !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL single_pop: got valid %b level %0d want 0 0", host_if.host_valid, level); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1 || level !== 4'd8) begin n_fail++; $display("FAIL fill_full: got full %b level %0d want 1 8", full, level); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (host_if.host_valid !== 1'b1 || host_if.host_data !== W'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h valid %b want %h", i, host_if.host_data, host_if.host_valid, i); end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++; if (level !== 4'd0 || full !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got level %0d full %b want 0 0", level, full); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, W'(32'hBAD0 + i), 1'b0, 1'b0);
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", level); end
    n_checks++; if (ovf_cnt !== 16'd3) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 3", ovf_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (host_if.host_data !== W'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, host_if.host_data, i); end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL ovf_clr_plain: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_full_passthrough();
    logic [W-1:0] want;
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      want = exp_q[0];
      n_checks++; if (host_if.host_data !== want) begin n_fail++; $display("FAIL pass_head[%0d]: got %h want %h", i, host_if.host_data, want); end
      step(1'b1, W'(32'h200 + i), 1'b1, 1'b0);
      n_checks++; if (level !== 4'd8 || full !== 1'b1 || ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL pass_level[%0d]: got level %0d full %b ovf %0d want 8 1 0", i, level, full, ovf_cnt); end
    end
    while (exp_q.size() != 0) begin
      want = exp_q[0];
      n_checks++; if (host_if.host_data !== want || host_if.host_valid !== 1'b1) begin n_fail++; $display("FAIL pass_drain: got %h want %h", host_if.host_data, want); end
      step(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16'hFFFE; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    n_checks++; if (ovf_cnt !== 16'hFFFE || ovf_cnt !== 16'(exp_ovf)) begin n_fail++; $display("FAIL sat_preload: got %h want fffe", ovf_cnt); end
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    n_checks++; if (ovf_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", ovf_cnt); end
    step(1'b1, W'($urandom), 1'b0, 1'b1);
    n_checks++; if (ovf_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_clr_drop: got %h want 0001", ovf_cnt); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_clr: got %h want 0000", ovf_cnt); end
    while (exp_q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] want;
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
      n_checks++;
      if (level !== 4'(exp_q.size()) || full !== (exp_q.size() == DEPTH) ||
          host_if.host_valid !== (exp_q.size() != 0) || ovf_cnt !== 16'(exp_ovf)) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: got level %0d full %b valid %b ovf %0d want %0d %b %b %0d", i, level, full,
                 host_if.host_valid, ovf_cnt, exp_q.size(), exp_q.size() == DEPTH, exp_q.size() != 0, exp_ovf);
      end
      if (exp_q.size() != 0) begin
        want = exp_q[0];
        n_checks++; if (host_if.host_data !== want) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, host_if.host_data, want); end
      end
    end
    while (exp_q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(32'h300 + i), 1'b0, 1'b0);
    step(1'b1, 32'h3FF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (level !== 4'd5 || ovf_cnt !== 16'd1) begin n_fail++; $display("FAIL pre_reset: got level %0d ovf %0d want 5 1", level, ovf_cnt); end
    host_if.host_ready = 1'b0; cap_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    exp_q.delete(); exp_ovf = 0;
    n_checks++; if (level !== 4'd0 || full !== 1'b0 || host_if.host_valid !== 1'b0 || ovf_cnt !== 16'd0) begin
      n_fail++; $display("FAIL async_reset: got level %0d full %b valid %b ovf %0d want 0 0 0 0", level, full, host_if.host_valid, ovf_cnt);
    end
    @(negedge clk); rst = 1'b1;
    step(1'b1, 32'h12345678, 1'b0, 1'b0);
    n_checks++; if (host_if.host_data !== 32'h12345678 || level !== 4'd1 || host_if.host_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_reset: got %h level %0d valid %b want 12345678 1 1", host_if.host_data, level, host_if.host_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_full_passthrough();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
